// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared arbiter state/owner types and default timing parameters.
package rv32i_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} arb_owner_e;
    localparam int MEM_LAT_DEFAULT  = 2;
    localparam int MAX_WAIT_DEFAULT = 4;
endpackage

// File: rtl/arb_prio_starve.sv
// arb_prio_starve: LS-priority winner select with a saturating IF starvation counter.
module arb_prio_starve
    import rv32i_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_req,
    input  logic ls_req,
    output logic win_if,
    output logic win_ls
);
    localparam int CW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);
    logic [CW-1:0] starve;
    always_comb begin
        win_ls = ls_req && !(if_req && starve == LIMIT);
        win_if = if_req && !win_ls;
    end
    // Decisions are only made in IDLE, so the counter only moves there.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            starve <= '0;
        else if (idle)
            starve <= (!if_req || win_if) ? '0 :
                      (win_ls && starve != LIMIT) ? starve + CW'(1) : starve;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between fetch and load/store.
module mem_port_arbiter
    import rv32i_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = MEM_LAT_DEFAULT,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    arb_state_e state;
    arb_owner_e owner;
    logic [3:0] wait_cnt;
    logic       win_if, win_ls, capture;

    arb_prio_starve #(.MAX_WAIT(MAX_WAIT)) u_prio (
        .clk    (clk),
        .rst    (rst),
        .idle   (state == IDLE),
        .if_req (if_req),
        .ls_req (ls_req),
        .win_if (win_if),
        .win_ls (win_ls)
    );

    // mem_rdata is sampled on the MEM_LAT-th edge after the mem_en cycle.
    assign capture = (state == ISSUE && MEM_LAT == 1) || (state == WAIT && wait_cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            wait_cnt  <= '0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_gnt    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            mem_en    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            case (state)
                IDLE: if (win_if || win_ls) begin
                    state     <= ISSUE;
                    busy      <= 1'b1;
                    mem_en    <= 1'b1;
                    if_gnt    <= win_if;
                    ls_gnt    <= win_ls;
                    owner     <= win_ls ? OWN_LS : OWN_IF;
                    mem_addr  <= win_ls ? ls_addr : if_addr;
                    mem_we    <= win_ls && ls_we;
                    mem_wstrb <= (win_ls && ls_we) ? ls_wstrb : '0;
                    mem_wdata <= win_ls ? ls_wdata : '0;
                end
                ISSUE: begin
                    state    <= MEM_LAT == 1 ? RESP : WAIT;
                    wait_cnt <= 4'(MEM_LAT - 2);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd0)
                        state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    owner <= OWN_NONE;
                end
            endcase
            if (capture) begin
                if_rvalid <= owner == OWN_IF;
                ls_rvalid <= owner == OWN_LS;
                if_rdata  <= owner == OWN_IF ? mem_rdata : '0;
                ls_rdata  <= (owner == OWN_LS && !mem_we) ? mem_rdata : '0;
            end
        end
    end
endmodule
